// File: rtl/atan2_cordic.sv
// atan2_cordic: iterative CORDIC vectoring unit.
// Converts a stationary-frame vector (alpha, beta) into its electrical angle theta
// (full scale 2^ANGLE_WIDTH = 360 degrees) and its gain-compensated, saturated magnitude.
// Processes one vector at a time: IDLE -> FOLD -> ITER x ITERATIONS -> SCALE -> DONE.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   alpha      in   signed alpha component
//   beta       in   signed beta component
//   in_valid   in   alpha/beta valid
//   in_ready   out  block can accept a vector
//   theta      out  unsigned angle, 0x4000 = 90 deg, 0x8000 = 180 deg
//   magnitude  out  unsigned |(alpha, beta)|
//   out_valid  out  theta/magnitude valid
//   out_ready  in   downstream accepts the result
module atan2_cordic #(
    parameter int unsigned DATA_WIDTH  = 18,
    parameter int unsigned ANGLE_WIDTH = 16,
    parameter int unsigned ITERATIONS  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic signed [DATA_WIDTH-1:0]  alpha,
    input  logic signed [DATA_WIDTH-1:0]  beta,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic        [ANGLE_WIDTH-1:0] theta,
    output logic        [DATA_WIDTH-1:0]  magnitude,
    output logic                          out_valid,
    input  logic                          out_ready
);

    // Two guard bits: CORDIC gain (1.647), sqrt(2) corner and negating the most negative input.
    localparam int unsigned XW     = DATA_WIDTH + 2;
    localparam int unsigned CntW   = $clog2(ITERATIONS);
    localparam int unsigned AngUp  = (ANGLE_WIDTH >= 16) ? ANGLE_WIDTH - 16 : 0;
    localparam int unsigned AngDn  = (ANGLE_WIDTH < 16) ? 16 - ANGLE_WIDTH : 0;
    localparam logic [15:0] KGain  = 16'h9B75;  // 1/1.64676 in Q0.16
    localparam logic [XW-1:0] MaxMag = {3'b000, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {StIdle, StFold, StIter, StScale, StDone} state_e;

    // atan(2^-i) in 16-bit angle scale, rescaled to ANGLE_WIDTH.
    function automatic logic [ANGLE_WIDTH-1:0] atan_lut(input logic [CntW-1:0] idx);
        logic [15:0] base;
        case (int'(idx))
            0:       base = 16'h2000;
            1:       base = 16'h12E4;
            2:       base = 16'h09FB;
            3:       base = 16'h0511;
            4:       base = 16'h028B;
            5:       base = 16'h0146;
            6:       base = 16'h00A3;
            7:       base = 16'h0051;
            8:       base = 16'h0029;
            9:       base = 16'h0014;
            10:      base = 16'h000A;
            11:      base = 16'h0005;
            12:      base = 16'h0003;
            13:      base = 16'h0001;
            14:      base = 16'h0001;
            default: base = 16'h0000;
        endcase
        return ANGLE_WIDTH'((64'(base) << AngUp) >> AngDn);
    endfunction

    state_e                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    zero_q, zero_d;
    logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
    logic [ANGLE_WIDTH-1:0]  z_q, z_d;
    logic [CntW-1:0]         i_q, i_d;
    logic [ANGLE_WIDTH-1:0]  theta_q, theta_d;
    logic [DATA_WIDTH-1:0]   mag_q, mag_d;

    logic signed [XW-1:0]    x_sh, y_sh;
    logic [XW+15:0]          prod;
    logic [XW-1:0]           scaled;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        zero_d      = zero_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        i_d         = i_q;
        theta_d     = theta_q;
        mag_d       = mag_q;
        x_sh        = x_q >>> i_q;
        y_sh        = y_q >>> i_q;
        // x is non-negative from FOLD onward, so an unsigned multiply is exact.
        prod        = (XW+16)'($unsigned(x_q)) * (XW+16)'(KGain);
        scaled      = XW'(prod >> 16);

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    x_d     = XW'(alpha);
                    y_d     = XW'(beta);
                    zero_d  = (alpha == '0) && (beta == '0);
                    state_d = StFold;
                end
            end
            StFold: begin
                // Rotate left half-plane vectors by 180 deg so CORDIC converges.
                if (x_q[XW-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};
                end else begin
                    z_d = '0;
                end
                i_d     = '0;
                state_d = StIter;
            end
            StIter: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_lut(i_q);
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_lut(i_q);
                end
                if (i_q == CntW'(ITERATIONS - 1)) begin
                    state_d = StScale;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            StScale: begin
                // A zero vector would otherwise report the sum of the whole atan table.
                theta_d     = zero_q ? '0 : z_q;
                mag_d       = (scaled > MaxMag) ? MaxMag[DATA_WIDTH-1:0] : scaled[DATA_WIDTH-1:0];
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered so in_ready stays low while reset is asserted.
        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            i_q         <= '0;
            theta_q     <= '0;
            mag_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            i_q         <= i_d;
            theta_q     <= theta_d;
            mag_q       <= mag_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign theta     = theta_q;
    assign magnitude = mag_q;

endmodule

// File: tb/tb_atan2_cordic.sv
// tb_atan2_cordic: directed and swept checks of atan2_cordic (reset, axis/diagonal
// vectors, saturation, latency, handshake, backpressure, mid-run reset, model sweep).
`timescale 1ns/1ps
module tb_atan2_cordic;

    localparam int DW = 18;
    localparam int AW = 16;
    localparam real PI = 3.14159265358979;

    logic                 clock = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] alpha, beta;
    logic                 in_valid, in_ready, out_valid, out_ready;
    logic [AW-1:0]        theta;
    logic [DW-1:0]        magnitude;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [AW-1:0] res_theta;
    logic [DW-1:0] res_mag;
    int            res_lat, res_busy;

    atan2_cordic #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .ITERATIONS(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .alpha     (alpha),
        .beta      (beta),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .theta     (theta),
        .magnitude (magnitude),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_asserts++;
        assert (d <= tol) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Circular angle comparison modulo 2^16.
    task automatic check_ang(input string tag, input logic [15:0] obs, input logic [15:0] exp,
                             input int tol);
        logic [15:0] dd;
        int          sd;
        dd = obs - exp;
        sd = int'(signed'(dd));
        if (sd < 0) sd = -sd;
        n_asserts++;
        assert (sd <= tol) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic check_real(input string tag, input real obs, input real exp, input real tol);
        real d;
        d = obs - exp;
        if (d < 0.0) d = -d;
        n_asserts++;
        assert (d <= tol) else begin
            n_fail++;
            $error("FAIL %s: observed %f expected %f (tol %f)", tag, obs, exp, tol);
        end
    endtask

    // Offers one vector, waits for the result; leaves time just after the edge that raised
    // out_valid. With junk set, in_valid toggles with garbage data while the block is busy.
    task automatic run_vec(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                           input bit junk);
        int g;
        g = 0;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        check_eq("accept_ready", in_ready, 1);
        alpha    = a;
        beta     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        res_lat  = 0;
        res_busy = 0;
        while (!out_valid && res_lat < 100) begin
            if (!in_ready) res_busy++;
            if (junk) begin
                in_valid = res_lat[0];
                alpha    = DW'($urandom);
                beta     = DW'($urandom);
            end
            tick();
            res_lat++;
        end
        in_valid = 1'b0;
        if (!in_ready) res_busy++;
        check_eq("out_valid_seen", out_valid, 1);
        res_theta = theta;
        res_mag   = magnitude;
    endtask

    int tv_a  [10] = '{40960, 0, -20480, 20480, 131071, -131072, 32768, -49152, 24576, 0};
    int tv_b  [10] = '{0, -40960, 0, 20480, 131071, -131072, -32768, 49152, 32768, 0};
    int tv_th [10] = '{'h0000, 'hC000, 'h8000, 'h2000, 'h2000, 'hA000, 'hE000, 'h6000,
                       'h25C8, 'h0000};
    int tv_mg [10] = '{'h0A000, 'h0A000, 'h05000, 'h07123, 'h1FFFF, 'h1FFFF, 'h0B505,
                       'h10F87, 'h0A000, 'h00000};

    initial begin
        logic [AW-1:0] th0;
        logic [DW-1:0] mg0;
        bit            stable, rdy_any, seen;
        logic [31:0]   r;
        real           ar, br, hyp, exp_th, exp_mg, t, d, q;
        int            exp_ti;

        reset     = 1'b1;
        alpha     = '0;
        beta      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 reset  = 1'b0;
        #2;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_theta", theta, 0);
        check_eq("rst_magnitude", magnitude, 0);
        tick();
        tick();
        check_eq("rst_held_in_ready", in_ready, 0);
        reset = 1'b1;
        check_eq("rst_release_in_ready", in_ready, 0);
        tick();
        check_eq("rst_first_edge_in_ready", in_ready, 1);

        // Directed vectors with out_ready tied high.
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            run_vec(DW'(tv_a[k]), DW'(tv_b[k]), 1'b0);
            if (k == 9) begin
                check_eq("zero_theta", res_theta, 0);
                check_eq("zero_magnitude", res_mag, 0);
            end else begin
                check_ang("vec_theta", res_theta, 16'(tv_th[k]), 2);
                check_near("vec_magnitude", int'(res_mag), tv_mg[k], tv_mg[k] / 1000);
            end
            tick();
        end

        // Latency and handshake, with in_valid pulses while busy.
        run_vec(18'sh04000, 18'sh00000, 1'b1);
        check_eq("latency_edges", res_lat, 18);
        check_eq("in_ready_low_cycles", res_busy, 19);
        check_ang("busy_theta", res_theta, 16'h0000, 2);
        check_near("busy_magnitude", int'(res_mag), 'h04000, 16);
        tick();
        check_eq("out_valid_one_cycle", out_valid, 0);
        check_eq("in_ready_after_done", in_ready, 1);

        // Backpressure.
        out_ready = 1'b0;
        run_vec(-18'sd40960, 18'sd20480, 1'b0);
        check_ang("bp_theta", res_theta, 16'h6D1C, 2);
        check_near("bp_magnitude", int'(res_mag), 45795, 45);
        th0     = res_theta;
        mg0     = res_mag;
        stable  = 1'b1;
        rdy_any = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!(out_valid === 1'b1 && theta === th0 && magnitude === mg0)) stable = 1'b0;
            if (in_ready !== 1'b0) rdy_any = 1'b1;
        end
        check_eq("bp_outputs_stable", stable, 1);
        check_eq("bp_in_ready_low", rdy_any, 0);
        out_ready = 1'b1;
        tick();
        check_eq("bp_release_out_valid", out_valid, 0);
        check_eq("bp_release_in_ready", in_ready, 1);
        check_ang("bp_theta_hold", theta, 16'h6D1C, 2);

        // Reset during ITER with i = 7.
        alpha    = 18'sh06000;
        beta     = 18'sh08000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        reset = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_theta", theta, 0);
        check_eq("midrst_magnitude", magnitude, 0);
        check_eq("midrst_in_ready", in_ready, 0);
        tick();
        tick();
        reset = 1'b1;
        check_eq("midrst_release_in_ready", in_ready, 0);
        tick();
        check_eq("midrst_edge_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check_eq("midrst_no_out_valid", seen, 0);
        run_vec(18'sh06000, 18'sh08000, 1'b0);
        check_ang("midrst_new_theta", res_theta, 16'h25C8, 2);
        check_near("midrst_new_magnitude", int'(res_mag), 'h0A000, 40);
        tick();

        // Random sweep against real atan2/hypot and a park transform.
        for (int n = 0; n < 1000; n++) begin
            r     = $urandom;
            alpha = r[DW-1:0];
            r     = $urandom;
            beta  = r[DW-1:0];
            // Keep |v| large enough that quantisation stays inside the tolerances.
            if (alpha >= -18'sd32768 && alpha <= 18'sd32767 &&
                beta >= -18'sd32768 && beta <= 18'sd32767) begin
                alpha = alpha ^ 18'sh10000;
            end
            ar  = alpha;
            br  = beta;
            hyp = $sqrt(ar * ar + br * br);
            exp_th = $atan2(br, ar) * 65536.0 / (2.0 * PI);
            if (exp_th < 0.0) exp_th = exp_th + 65536.0;
            exp_ti = int'(exp_th);
            exp_mg = (hyp > 131071.0) ? 131071.0 : hyp;
            run_vec(alpha, beta, 1'b0);
            check_ang("sweep_theta", res_theta, 16'(exp_ti), 6);
            check_real("sweep_magnitude", real'(res_mag), exp_mg, exp_mg * 0.001 + 8.0);
            t = real'(res_theta) * 2.0 * PI / 65536.0;
            d = ar * $cos(t) + br * $sin(t);
            q = br * $cos(t) - ar * $sin(t);
            check_real("sweep_park_d", d, exp_mg + (hyp - exp_mg), hyp * 0.001 + 8.0);
            if (hyp <= 131071.0) check_real("sweep_park_d_mag", real'(res_mag), d, d * 0.001 + 8.0);
            check_real("sweep_park_q", q, 0.0, hyp * 0.0006 + 8.0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/atan2_cordic.md
# atan2_cordic

Iterative CORDIC vectoring unit that converts a stationary-frame vector (alpha, beta) into its electrical angle theta and magnitude. It is the inverse direction of the park/antiPark pair: those blocks consume theta, and this block produces it. It sits between the Clarke output and the park/antiPark theta input, for sensorless angle estimation and PLL seeding. It uses a valid/ready handshake on both sides and processes one vector at a time.

## Interface
- DATA_WIDTH, 18: width of signed alpha, beta and unsigned magnitude.
- ANGLE_WIDTH, 16: width of theta; full scale 2^ANGLE_WIDTH = 360°.
- ITERATIONS, 16: CORDIC micro-rotations; legal range 8..ANGLE_WIDTH.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- alpha  in  DATA_WIDTH  signed two's complement alpha component.
- beta  in  DATA_WIDTH  signed two's complement beta component.
- in_valid  in  1  alpha/beta valid.
- in_ready  out  1  block can accept a vector.
- theta  out  ANGLE_WIDTH  unsigned angle: 0x4000 = 90°, 0x8000 = 180°.
- magnitude  out  DATA_WIDTH  unsigned |(alpha, beta)|, gain-compensated and saturated.
- out_valid  out  1  theta/magnitude valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture alpha/beta → FOLD.
  - FOLD: one cycle → ITER.
  - ITER: ITERATIONS cycles, counter i = 0..ITERATIONS-1, → SCALE.
  - SCALE: one cycle → DONE.
  - DONE: out_valid=1; on out_ready → IDLE.
- Internal x/y width is DATA_WIDTH+2 signed. This covers the CORDIC gain of 1.647, the √2 corner case and negation of -2^(DATA_WIDTH-1).
- FOLD: if x<0, set x=-x, y=-y, z=0x8000; otherwise z=0. This brings the vector into the right half-plane.
- ITER step i, using arithmetic shifts:
  - If y≥0: x+=y>>>i, y-=x>>>i, z+=atan_i.
  - Otherwise: x-=y>>>i, y+=x>>>i, z-=atan_i.
  - x and y update simultaneously from the previous values.
- atan_i is a constant ROM, rounded, in 16-bit scale: 2000, 12E4, 09FB, 0511, 028B, 0146, 00A3, 0051, 0029, 0014, 000A, 0005, 0003, 0001, 0001, 0000 (hex).
- For ANGLE_WIDTH≠16, entries are scaled by 2^(ANGLE_WIDTH-16).
- z accumulates modulo 2^ANGLE_WIDTH, so wrap-around is intentional. Negative angles map to 0x8000..0xFFFF.
- SCALE:
  - magnitude = (x × 0x9B75) >> 16, where K = 0.60725 in Q0.16.
  - Saturate to 2^(DATA_WIDTH-1)-1 if the result exceeds it. The output is always non-negative.
  - theta = z.
- alpha=beta=0 → theta=0, magnitude=0.
- in_valid while not in IDLE is ignored; upstream must hold data until in_ready.

## Timing
- Reset asserted (asynchronous):
  - State → IDLE; theta=0, magnitude=0, out_valid=0, in_ready=0.
  - in_ready rises on the first rising edge after reset deasserts.
- Reset mid-operation aborts. The pending vector and result are discarded, and no out_valid is produced.
- Accepting edge: in_valid & in_ready high at the rising edge. in_ready drops after that edge.
- Latency: out_valid rises ITERATIONS+2 rising edges after the accepting edge (18 cycles at default).
- theta and magnitude are registered and change only on the edge that raises out_valid. They hold their last value after the handshake.
- DONE with out_ready=1 at an edge:
  - out_valid falls after that edge, and in_ready rises.
  - Throughput: one vector per ITERATIONS+4 cycles minimum.
- out_ready held low: out_valid, theta and magnitude remain stable indefinitely, and in_ready stays 0.
- out_ready high before out_valid has no effect.

## Test plan
- Axis cases (tolerance theta ±2 LSB, magnitude ±0.1%):
  - alpha=0x0A000, beta=0 → theta=0x0000, magnitude=0x0A000.
  - alpha=0, beta=-0x0A000 → theta=0xC000, magnitude=0x0A000.
  - alpha=-0x05000, beta=0 → theta=0x8000, magnitude=0x05000.
- Diagonal and saturation:
  - alpha=beta=0x05000 → theta=0x2000, magnitude=0x07123.
  - alpha=beta=0x1FFFF → theta=0x2000, magnitude saturated to 0x1FFFF.
  - alpha=beta=-0x20000 → theta=0xA000, magnitude=0x1FFFF.
- Latency and handshake:
  - Single vector with out_ready tied high → out_valid high for exactly 1 cycle, 18 edges after accept.
  - in_ready low for 19 cycles.
  - in_valid pulses during busy are ignored.
- Backpressure: hold out_ready low for 10 cycles after out_valid → theta, magnitude and out_valid stable, in_ready=0; release → IDLE next edge.
- Reset mid-ITER (i=7), then deassert → no out_valid, outputs 0, in_ready=1 one edge later; a new vector completes correctly.
- Sweep: random 1000 vectors checked against a real atan2/hypot model, and park(alpha, beta, theta) d-output ≈ magnitude, q ≈ 0.
